// File: rtl/addsub_result_normalizer_if.sv
// Handshake and data bundle between the FP add/sub front end, this normalizer
// and the rounding stage.
interface addsub_result_normalizer_if #(
  parameter int MW = 23,
  parameter int EW = 8
);
  logic          in_valid;
  logic          in_ready;
  logic          eff_op_i;
  logic [MW+1:0] sum_i;
  logic          sum_neg_i;
  logic [EW-1:0] exp_i;
  logic          sign_i;
  logic          out_valid;
  logic          out_ready;
  logic [MW:0]   mant_o;
  logic [EW-1:0] exp_o;
  logic          sign_o;
  logic          sticky_o;
  logic          zero_o;
  logic          ovf_o;

  modport slave (
    input  in_valid, eff_op_i, sum_i, sum_neg_i, exp_i, sign_i, out_ready,
    output in_ready, out_valid, mant_o, exp_o, sign_o, sticky_o, zero_o, ovf_o
  );

  modport master (
    output in_valid, eff_op_i, sum_i, sum_neg_i, exp_i, sign_i, out_ready,
    input  in_ready, out_valid, mant_o, exp_o, sign_o, sticky_o, zero_o, ovf_o
  );
endinterface

// File: rtl/addsub_result_normalizer.sv
// Back end of the FP add/sub datapath: restores magnitude and sign of the raw
// adder result, normalizes it one bit per cycle and hands it to rounding.
module addsub_result_normalizer #(
  parameter int MW = 23,
  parameter int EW = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  addsub_result_normalizer_if.slave    io
);

  typedef enum logic [1:0] {IDLE, FIX, NORM, DONE} state_t;

  state_t        state;
  logic          op_r;
  logic          neg_r;
  logic          shifted;
  logic [MW+1:0] mant_r;
  logic [EW-1:0] exp_r;
  logic          sign_r;
  logic          sticky_r;
  logic          zero_r;
  logic          ovf_r;
  logic          in_ready_r;
  logic          out_valid_r;

  logic [MW+1:0] fix_mant;
  logic [EW-1:0] fix_exp;
  logic [EW-1:0] exp_inc;
  logic          fix_sign;
  logic          fix_sticky;
  logic          fix_zero;
  logic          fix_ovf;

  // First-match case selection for the fix-up cycle.
  always_comb begin
    fix_mant   = mant_r;
    fix_exp    = exp_r;
    fix_sign   = sign_r;
    fix_sticky = 1'b0;
    fix_zero   = 1'b0;
    fix_ovf    = 1'b0;
    exp_inc    = exp_r + 1'b1;
    if (op_r && neg_r) begin
      fix_mant = -mant_r;
      fix_sign = ~sign_r;
    end else if (!op_r && mant_r[MW+1]) begin
      fix_mant   = mant_r >> 1;
      fix_sticky = mant_r[0];
      fix_exp    = exp_inc;
      if (exp_inc == '1) begin
        fix_ovf  = 1'b1;
        fix_mant = '0;
      end
    end else if (!op_r && exp_r == '0 && mant_r[MW]) begin
      fix_exp = EW'(1);
    end else if (mant_r == '0) begin
      fix_zero = 1'b1;
      fix_sign = 1'b0;
      fix_exp  = '0;
      fix_mant = '0;
    end
  end

  // Every op passes through NORM at least once so that out_valid always rises
  // two edges after acceptance plus one edge per left shift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      op_r        <= 1'b0;
      neg_r       <= 1'b0;
      shifted     <= 1'b0;
      mant_r      <= '0;
      exp_r       <= '0;
      sign_r      <= 1'b0;
      sticky_r    <= 1'b0;
      zero_r      <= 1'b0;
      ovf_r       <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (io.in_valid) begin
            op_r       <= io.eff_op_i;
            neg_r      <= io.sum_neg_i;
            mant_r     <= io.sum_i;
            exp_r      <= io.exp_i;
            sign_r     <= io.sign_i;
            sticky_r   <= 1'b0;
            zero_r     <= 1'b0;
            ovf_r      <= 1'b0;
            shifted    <= 1'b0;
            in_ready_r <= 1'b0;
            state      <= FIX;
          end
        end
        FIX: begin
          mant_r   <= fix_mant;
          exp_r    <= fix_exp;
          sign_r   <= fix_sign;
          sticky_r <= fix_sticky;
          zero_r   <= fix_zero;
          ovf_r    <= fix_ovf;
          state    <= NORM;
        end
        NORM: begin
          if (zero_r || ovf_r || mant_r[MW]) begin
            out_valid_r <= 1'b1;
            state       <= DONE;
          end else if (exp_r > EW'(1)) begin
            mant_r  <= mant_r << 1;
            exp_r   <= exp_r - 1'b1;
            shifted <= 1'b1;
          end else begin
            // Only a shifted-down result becomes subnormal; an unshifted one keeps its exponent.
            if (shifted && exp_r == EW'(1)) exp_r <= '0;
            out_valid_r <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          if (io.out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign io.in_ready  = in_ready_r;
  assign io.out_valid = out_valid_r;
  assign io.mant_o    = mant_r[MW:0];
  assign io.exp_o     = exp_r;
  assign io.sign_o    = sign_r;
  assign io.sticky_o  = sticky_r;
  assign io.zero_o    = zero_r;
  assign io.ovf_o     = ovf_r;

endmodule

// File: tb/tb_addsub_result_normalizer.sv
// Scoreboard bench for addsub_result_normalizer: hand-derived expectations are
// queued at drive time and compared when out_valid rises.
module tb_addsub_result_normalizer;
  localparam int MW = 23;
  localparam int EW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  addsub_result_normalizer_if #(.MW(MW), .EW(EW)) bus ();

  addsub_result_normalizer #(.MW(MW), .EW(EW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (bus)
  );

  typedef struct {
    logic [MW:0]   mant;
    logic [EW-1:0] exp;
    logic          sign;
    logic          sticky;
    logic          zero;
    logic          ovf;
    int            lat;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  task automatic drive(input logic op, input logic [MW+1:0] sum, input logic neg,
                       input logic [EW-1:0] e, input logic s);
    int guard = 0;
    @(negedge clk);
    while (!bus.in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("in_ready_before_op", 32'(bus.in_ready), 32'd1);
    bus.eff_op_i  = op;
    bus.sum_i     = sum;
    bus.sum_neg_i = neg;
    bus.exp_i     = e;
    bus.sign_i    = s;
    bus.in_valid  = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check("in_ready_after_accept", 32'(bus.in_ready), 32'd0);
  endtask

  task automatic collect(input int hold);
    exp_t e;
    int cyc = 0;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    while (!bus.out_valid && cyc < 60) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("out_valid_seen", 32'(bus.out_valid), 32'd1);
    check("latency", 32'(cyc), 32'(e.lat));
    check("mant", 32'(bus.mant_o), 32'(e.mant));
    check("exp", 32'(bus.exp_o), 32'(e.exp));
    check("sign", 32'(bus.sign_o), 32'(e.sign));
    check("sticky", 32'(bus.sticky_o), 32'(e.sticky));
    check("zero", 32'(bus.zero_o), 32'(e.zero));
    check("ovf", 32'(bus.ovf_o), 32'(e.ovf));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check("hold_valid", 32'(bus.out_valid), 32'd1);
      check("hold_mant", 32'(bus.mant_o), 32'(e.mant));
      check("hold_exp", 32'(bus.exp_o), 32'(e.exp));
      check("hold_in_ready", 32'(bus.in_ready), 32'd0);
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check("valid_drop", 32'(bus.out_valid), 32'd0);
    check("ready_back", 32'(bus.in_ready), 32'd1);
  endtask

  task automatic run_op(input logic op, input logic [MW+1:0] sum, input logic neg,
                        input logic [EW-1:0] e, input logic s,
                        input logic [MW:0] x_mant, input logic [EW-1:0] x_exp,
                        input logic x_sign, input logic x_sticky, input logic x_zero,
                        input logic x_ovf, input int x_lat, input int hold);
    exp_t x;
    x.mant = x_mant; x.exp = x_exp; x.sign = x_sign; x.sticky = x_sticky;
    x.zero = x_zero; x.ovf = x_ovf; x.lat = x_lat;
    sb.push_back(x);
    drive(op, sum, neg, e, s);
    collect(hold);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.eff_op_i  = 1'b0;
    bus.sum_i     = '0;
    bus.sum_neg_i = 1'b0;
    bus.exp_i     = '0;
    bus.sign_i    = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_mant", 32'(bus.mant_o), 32'd0);
    check("rst_flags", {29'd0, bus.sticky_o, bus.zero_o, bus.ovf_o}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // op sum neg exp sign | mant exp sign sticky zero ovf lat hold
    run_op(1'b0, 25'h1800001, 1'b0, 8'h7F, 1'b0, 24'hC00000, 8'h80, 1'b0, 1'b1, 1'b0, 1'b0, 2, 0);
    run_op(1'b1, 25'h0200000, 1'b0, 8'h80, 1'b0, 24'h800000, 8'h7E, 1'b0, 1'b0, 1'b0, 1'b0, 4, 0);
    run_op(1'b1, 25'h0000000, 1'b0, 8'h40, 1'b1, 24'h000000, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 2, 0);
    run_op(1'b1, 25'h1FFFFFF, 1'b1, 8'h80, 1'b0, 24'h800000, 8'h69, 1'b1, 1'b0, 1'b0, 1'b0, 25, 0);
    run_op(1'b1, 25'h0000100, 1'b0, 8'h03, 1'b0, 24'h000400, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 4, 0);
    run_op(1'b0, 25'h1000000, 1'b0, 8'hFE, 1'b0, 24'h000000, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 2, 5);
    run_op(1'b0, 25'h0900000, 1'b0, 8'h10, 1'b1, 24'h900000, 8'h10, 1'b1, 1'b0, 1'b0, 1'b0, 2, 0);
    run_op(1'b0, 25'h0800001, 1'b0, 8'h00, 1'b0, 24'h800001, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 2, 0);
    run_op(1'b1, 25'h0400000, 1'b0, 8'h05, 1'b1, 24'h800000, 8'h04, 1'b1, 1'b0, 1'b0, 1'b0, 3, 0);

    // Reset partway through a long normalization discards the op.
    drive(1'b1, 25'h1FFFFFF, 1'b1, 8'h80, 1'b0);
    repeat (6) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    check("midrst_mant", 32'(bus.mant_o), 32'd0);
    check("midrst_exp", 32'(bus.exp_o), 32'd0);
    check("midrst_sign", 32'(bus.sign_o), 32'd0);
    check("midrst_flags", {29'd0, bus.sticky_o, bus.zero_o, bus.ovf_o}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(1'b0, 25'h1800001, 1'b0, 8'h7F, 1'b0, 24'hC00000, 8'h80, 1'b0, 1'b1, 1'b0, 1'b0, 2, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
